gamepad_reader: RTL

Serial front end for the NES-style controller on the PMOD header. It periodically latches and shifts in the 8 button states, synchronises and inverts the active-low data line, and filters out opposing directions. It presents registered, stable button levels to the player logic stage: A, B, select, start, up, down, left, right. A one-cycle strobe marks each fresh sample, so downstream logic can step once per poll instead of once per clock.

---
 rtl/gamepad_reader.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/gamepad_reader.sv
// +--------------------------------------------------------------------------+
// | gamepad_reader: polls an NES-style pad, syncs/inverts data, filters       |
// | opposing directions, registers button levels with a per-poll strobe. r1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module gamepad_reader #(
   parameter int HALF_PERIOD   = 6,
   parameter int POLL_INTERVAL = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic pad_data,
   output logic pad_latch,
   output logic pad_clk,
   output logic A,
   output logic B,
   output logic select,
   output logic start,
   output logic up,
   output logic down,
   output logic left,
   output logic right,
   output logic valid
);

   localparam int PCW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
   localparam int TMW = $clog2(2 * HALF_PERIOD);

   localparam logic [PCW-1:0] POLL_LAST  = PCW'(POLL_INTERVAL - 1);
   localparam logic [TMW-1:0] LATCH_LAST = TMW'(2 * HALF_PERIOD - 1);
   localparam logic [TMW-1:0] HALF_LAST  = TMW'(HALF_PERIOD - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LATCH    = 3'd1,
      S_CLK_LOW  = 3'd2,
      S_CLK_HIGH = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t         state_q, state_d;
   logic [PCW-1:0] poll_q, poll_d;
   logic [TMW-1:0] timer_q, timer_d;
   logic [2:0]     idx_q, idx_d;
   logic [7:0]     shadow_q, shadow_d;
   logic [7:0]     btn_q, btn_d;
   logic           valid_q, valid_d;
   logic           latch_q, latch_d;
   logic           pclk_q, pclk_d;
   logic           sync1_q, sync2_q;

   logic           w_bit;
   logic           w_ud_conflict;
   logic           w_lr_conflict;
   logic [7:0]     w_filtered;

   // Pad line idles high (released), so the synchroniser resets to 1.
   assign w_bit         = ~sync2_q;
   assign w_ud_conflict = shadow_q[4] & shadow_q[5];
   assign w_lr_conflict = shadow_q[6] & shadow_q[7];
   assign w_filtered    = {shadow_q[7:6] & {2{~w_lr_conflict}},
                           shadow_q[5:4] & {2{~w_ud_conflict}},
                           shadow_q[3:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         poll_q   <= '0;
         timer_q  <= '0;
         idx_q    <= 3'd0;
         shadow_q <= 8'h00;
         btn_q    <= 8'h00;
         valid_q  <= 1'b0;
         latch_q  <= 1'b0;
         pclk_q   <= 1'b0;
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         poll_q   <= poll_d;
         timer_q  <= timer_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         btn_q    <= btn_d;
         valid_q  <= valid_d;
         latch_q  <= latch_d;
         pclk_q   <= pclk_d;
         sync1_q  <= pad_data;
         sync2_q  <= sync1_q;
      end
   end

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      btn_d    = btn_q;
      valid_d  = 1'b0;
      poll_d   = (poll_q == POLL_LAST) ? '0 : poll_q + PCW'(1);

      case (state_q)
         S_IDLE: begin
            if (poll_q == '0) begin
               state_d = S_LATCH;
               timer_d = '0;
            end
         end
         S_LATCH: begin
            if (timer_q == LATCH_LAST) begin
               shadow_d[0] = w_bit;
               idx_d       = 3'd1;
               timer_d     = '0;
               state_d     = S_CLK_LOW;
            end else begin
               timer_d = timer_q + TMW'(1);
            end
         end
         S_CLK_LOW: begin
            if (timer_q == HALF_LAST) begin
               timer_d = '0;
               state_d = S_CLK_HIGH;
            end else begin
               timer_d = timer_q + TMW'(1);
            end
         end
         S_CLK_HIGH: begin
            if (timer_q == HALF_LAST) begin
               shadow_d[idx_q] = w_bit;
               timer_d         = '0;
               if (idx_q == 3'd7) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = S_CLK_LOW;
               end
            end else begin
               timer_d = timer_q + TMW'(1);
            end
         end
         S_DONE: begin
            btn_d   = w_filtered;
            valid_d = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Pad strobes are registered from the next state so they track the FSM without lag.
      latch_d = (state_d == S_LATCH);
      pclk_d  = (state_d == S_CLK_HIGH);
   end

   assign pad_latch = latch_q;
   assign pad_clk   = pclk_q;
   assign A         = btn_q[0];
   assign B         = btn_q[1];
   assign select    = btn_q[2];
   assign start     = btn_q[3];
   assign up        = btn_q[4];
   assign down      = btn_q[5];
   assign left      = btn_q[6];
   assign right     = btn_q[7];
   assign valid     = valid_q;

endmodule

`default_nettype wire
